// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcode fields, ALU op and FSM state encodings.
// CPU_DIV_EN enables the DIV opcodes; without it they decode as illegal.
package cpu_pkg;

  localparam int         OPC_MEM_BIT = 0;
  localparam logic [3:0] OPC_HALT    = 4'b1000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_OPA     = 3'd1,
    ST_OPA_IND = 3'd2,
    ST_OPB     = 3'd3,
    ST_OPB_IND = 3'd4,
    ST_EXEC    = 3'd5,
    ST_WRITE   = 3'd6,
    ST_HALTED  = 3'd7
  } state_e;

  function automatic logic opc_illegal(input logic [3:0] opc);
    logic ill;
    ill = 1'b0;
    if (opc != OPC_HALT) begin
      ill = opc[3];
`ifndef CPU_DIV_EN
      if (opc[2:1] == 2'b11) ill = 1'b1;
`endif
    end
    return ill;
  endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Single-port memory bus with req/ready handshake; the CPU is the master.
interface multicycle_cpu_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: ADD/SUB/MUL, plus an unsigned divider when CPU_DIV_EN is defined.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              carry,
  output logic              dz
);

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    y     = '0;
    carry = 1'b0;
    dz    = 1'b0;
    case (op)
      ALU_ADD: begin
        y     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      // Top bit of the zero-extended difference is the borrow.
      ALU_SUB: begin
        y     = diff[DATA_W-1:0];
        carry = diff[DATA_W];
      end
      ALU_MUL: begin
        y     = prod[DATA_W-1:0];
        carry = |prod[2*DATA_W-1:DATA_W];
      end
      default: begin
`ifdef CPU_DIV_EN
        if (b == '0) begin
          y  = '1;
          dz = 1'b1;
        end else begin
          y = a / b;
        end
`endif
      end
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU: fetch opcode, two immediate or memory-indirect operands, execute, write result.
// CPU_DIV_EN builds the divider and makes opcodes 0110/0111 legal.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                DATA_W      = 4,
  parameter int                ADDR_W      = 6,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_cpu_if.master        mem,
  output logic                    halted,
  output logic                    illegal_op,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic                    dz_flag
);

  localparam int NA = (ADDR_W + DATA_W - 1) / DATA_W;
  localparam int CW = (NA > 1) ? $clog2(NA) : 1;

  state_e            state, nxt_state;
  logic [ADDR_W-1:0] pc, nxt_pc;
  logic [ADDR_W-1:0] acc, nxt_acc;
  logic [CW-1:0]     wcnt, nxt_wcnt;
  logic [2:0]        opc;
  logic [DATA_W-1:0] a_q, b_q;
  logic              req_q, we_q, nxt_req, nxt_we;
  logic [ADDR_W-1:0] addr_q, nxt_addr;
  logic [DATA_W-1:0] wdata_q, nxt_wdata;
  logic              ill_q, nxt_ill;
  logic              z_q, c_q, dz_q;
  logic              done;
  logic [3:0]        fetched;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero, alu_carry, alu_dz;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (alu_op_e'(opc[2:1])),
    .a     (a_q),
    .b     (b_q),
    .y     (alu_y),
    .zero  (alu_zero),
    .carry (alu_carry),
    .dz    (alu_dz)
  );

  assign done    = req_q & mem.ready;
  assign fetched = mem.rdata[3:0];

  always_comb begin
    nxt_state = state;
    nxt_pc    = pc;
    nxt_acc   = acc;
    nxt_wcnt  = wcnt;
    nxt_ill   = ill_q;
    nxt_wdata = (state == ST_EXEC) ? alu_y : wdata_q;
    case (state)
      ST_FETCH: if (done) begin
        nxt_pc   = pc + ADDR_W'(1);
        nxt_wcnt = '0;
        if (fetched == OPC_HALT) begin
          nxt_state = ST_HALTED;
        end else if (opc_illegal(fetched)) begin
          nxt_state = ST_HALTED;
          nxt_ill   = 1'b1;
        end else begin
          nxt_state = ST_OPA;
        end
      end
      ST_OPA, ST_OPB: if (done) begin
        nxt_pc = pc + ADDR_W'(1);
        if (!opc[OPC_MEM_BIT]) begin
          nxt_state = (state == ST_OPA) ? ST_OPB : ST_EXEC;
        end else begin
          // Operand address arrives MSB word first; older words shift out the top.
          nxt_acc = ADDR_W'({acc, mem.rdata});
          if (wcnt == CW'(NA - 1)) begin
            nxt_wcnt  = '0;
            nxt_state = (state == ST_OPA) ? ST_OPA_IND : ST_OPB_IND;
          end else begin
            nxt_wcnt = wcnt + CW'(1);
          end
        end
      end
      ST_OPA_IND: if (done) nxt_state = ST_OPB;
      ST_OPB_IND: if (done) nxt_state = ST_EXEC;
      ST_EXEC:    nxt_state = ST_WRITE;
      ST_WRITE:   if (done) nxt_state = ST_FETCH;
      default:    nxt_state = ST_HALTED;
    endcase

    // Request for the state being entered is registered now, so transactions run back-to-back.
    nxt_req  = 1'b1;
    nxt_we   = 1'b0;
    nxt_addr = nxt_pc;
    case (nxt_state)
      ST_OPA_IND, ST_OPB_IND: nxt_addr = nxt_acc;
      ST_WRITE: begin
        nxt_we   = 1'b1;
        nxt_addr = RESULT_ADDR;
      end
      ST_EXEC, ST_HALTED: begin
        nxt_req  = 1'b0;
        nxt_addr = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= '0;
      wcnt    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ill_q   <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state   <= nxt_state;
      pc      <= nxt_pc;
      wcnt    <= nxt_wcnt;
      req_q   <= nxt_req;
      we_q    <= nxt_we;
      addr_q  <= nxt_addr;
      wdata_q <= nxt_wdata;
      ill_q   <= nxt_ill;
      if (state == ST_EXEC) begin
        z_q  <= alu_zero;
        c_q  <= alu_carry;
        dz_q <= alu_dz;
      end
    end
  end

  always_ff @(posedge clk) begin
    acc <= nxt_acc;
    if (done && state == ST_FETCH) opc <= fetched[2:0];
    if (done && ((state == ST_OPA && !opc[OPC_MEM_BIT]) || state == ST_OPA_IND)) a_q <= mem.rdata;
    if (done && ((state == ST_OPB && !opc[OPC_MEM_BIT]) || state == ST_OPB_IND)) b_q <= mem.rdata;
  end

  assign mem.req    = req_q;
  assign mem.we     = we_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign halted     = (state == ST_HALTED);
  assign illegal_op = ill_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
`ifdef CPU_DIV_EN
  assign dz_flag    = dz_q;
`else
  assign dz_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu with a wait-state-capable memory model.
`timescale 1ns/1ps
module tb_multicycle_cpu;

  localparam int DW = 4;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted, illegal_op, zero_flag, carry_flag, dz_flag;
  logic mem_ready;

  multicycle_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if),
    .halted     (halted),
    .illegal_op (illegal_op),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .dz_flag    (dz_flag)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] prog [0:63];
  logic [DW-1:0] mem  [0:63];
  int total = 0;
  int bad   = 0;
  int wait_n = 0;
  int wcnt_m = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  bit stab_en = 1'b0;
  bit pend = 1'b0;
  logic [AW-1:0] p_addr;
  logic p_we;

  assign mem_if.rdata = mem[mem_if.addr];
  assign mem_if.ready = mem_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) mem_ready = mem_if.req && (wcnt_m >= wait_n);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] = prog[i];
      cyc = 0; wcnt_m = 0; pend = 1'b0; wr_cnt = 0;
    end else begin
      if (stab_en && pend) begin
        chk("stab_req", mem_if.req, 1);
        chk("stab_addr", mem_if.addr, p_addr);
        chk("stab_we", mem_if.we, p_we);
      end
      pend   = mem_if.req && !mem_ready;
      p_addr = mem_if.addr;
      p_we   = mem_if.we;
      if (mem_if.req && mem_ready) begin
        wcnt_m = 0;
        if (mem_if.we) begin
          mem[mem_if.addr] = mem_if.wdata;
          wr_cnt++;
          wr_addr = mem_if.addr;
          wr_data = mem_if.wdata;
          wr_cyc  = cyc;
        end
      end else if (mem_if.req) begin
        wcnt_m++;
      end
      cyc++;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_write(input string tag, input int limit);
    for (int i = 0; i < limit && wr_cnt == 0; i++) @(negedge clk);
    chk({tag, "_wr_seen"}, wr_cnt, 1);
  endtask

  task automatic wait_halt(input string tag, input int limit);
    for (int i = 0; i < limit && !halted; i++) @(negedge clk);
    chk({tag, "_halted"}, halted, 1);
  endtask

  initial begin
    bit seen;
    // Immediate ADD 3+4, first run out of power-on reset
    clear_prog();
    prog[0] = 4'h0; prog[1] = 4'h3; prog[2] = 4'h4;
    do_reset();
    chk("rst_req", mem_if.req, 0);
    chk("rst_we", mem_if.we, 0);
    chk("rst_addr", mem_if.addr, 0);
    chk("rst_wdata", mem_if.wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ill", illegal_op, 0);
    chk("rst_flags", {zero_flag, carry_flag, dz_flag}, 0);
    wait_write("add", 40);
    chk("add_addr", wr_addr, 63);
    chk("add_data", wr_data, 7);
    chk("add_cyc", wr_cyc, 5);
    chk("add_zc", {zero_flag, carry_flag}, 0);
    chk("add_next_req", {mem_if.req, mem_if.we}, 2'b10);
    chk("add_next_pc", mem_if.addr, 3);

    // Memory-mode MUL 5*4 = 20 -> 4 with carry
    clear_prog();
    prog[0] = 4'h5; prog[1] = 4'h2; prog[2] = 4'h8; prog[3] = 4'h0; prog[4] = 4'h9;
    prog[6'h28] = 4'h5; prog[6'h09] = 4'h4;
    do_reset();
    wait_write("mul", 60);
    chk("mul_addr", wr_addr, 63);
    chk("mul_data", wr_data, 4);
    chk("mul_cyc", wr_cyc, 9);
    chk("mul_carry", carry_flag, 1);
    chk("mul_zero", zero_flag, 0);

    // SUB 2-5 -> 0xD with borrow
    clear_prog();
    prog[0] = 4'h2; prog[1] = 4'h2; prog[2] = 4'h5;
    do_reset();
    wait_write("sub", 40);
    chk("sub_data", wr_data, 4'hD);
    chk("sub_carry", carry_flag, 1);
    chk("sub_zero", zero_flag, 0);

    // ADD 8+8 -> 0 with zero and carry
    clear_prog();
    prog[0] = 4'h0; prog[1] = 4'h8; prog[2] = 4'h8;
    do_reset();
    wait_write("add88", 40);
    chk("add88_data", wr_data, 0);
    chk("add88_zc", {zero_flag, carry_flag}, 2'b11);

    // DIV 9/0
    clear_prog();
    prog[0] = 4'h6; prog[1] = 4'h9; prog[2] = 4'h0;
    do_reset();
`ifdef CPU_DIV_EN
    wait_write("div", 40);
    chk("div_data", wr_data, 4'hF);
    chk("div_dz", dz_flag, 1);
    chk("div_carry", carry_flag, 0);
`else
    wait_halt("div", 40);
    repeat (10) @(negedge clk);
    chk("div_ill", illegal_op, 1);
    chk("div_nowrite", wr_cnt, 0);
    chk("div_dz", dz_flag, 0);
`endif

    // Illegal opcode 1111, then reset must clear the sticky flag
    clear_prog();
    prog[0] = 4'hF;
    do_reset();
    wait_halt("ill", 40);
    chk("ill_flag", illegal_op, 1);
    do_reset();
    chk("ill_rst_clear", illegal_op, 0);
    chk("ill_rst_halted", halted, 0);

    // Three wait states on every access
    clear_prog();
    prog[0] = 4'h0; prog[1] = 4'h3; prog[2] = 4'h4;
    wait_n = 3; stab_en = 1'b1;
    do_reset();
    wait_write("ws", 200);
    chk("ws_addr", wr_addr, 63);
    chk("ws_data", wr_data, 7);
    chk("ws_zc", {zero_flag, carry_flag}, 0);
    wait_n = 0; stab_en = 1'b0;

    // HALT at pc 0: bus stays idle
    clear_prog();
    prog[0] = 4'h8; prog[1] = 4'h3; prog[2] = 4'h4;
    do_reset();
    wait_halt("halt", 40);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_if.req) seen = 1'b1;
    end
    chk("halt_req_idle", seen, 0);
    chk("halt_ill", illegal_op, 0);
    chk("halt_nowrite", wr_cnt, 0);

    // SUB then memory-mode MUL; reset in the middle of OPB
    clear_prog();
    prog[0] = 4'h2; prog[1] = 4'h2; prog[2] = 4'h5;
    prog[3] = 4'h5; prog[4] = 4'h2; prog[5] = 4'h8; prog[6] = 4'h0; prog[7] = 4'h9;
    prog[6'h28] = 4'h5; prog[6'h09] = 4'h4;
    do_reset();
    wait_write("mid", 40);
    chk("mid_sub_carry", carry_flag, 1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.req && !mem_if.we && mem_if.addr == 6) seen = 1'b1;
    end
    chk("mid_opb_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_req", mem_if.req, 0);
    chk("mid_rst_addr", mem_if.addr, 0);
    chk("mid_rst_wdata", mem_if.wdata, 0);
    chk("mid_rst_flags", {zero_flag, carry_flag, dz_flag}, 0);
    @(negedge clk);
    chk("mid_refetch", {mem_if.req, mem_if.we, mem_if.addr}, {1'b1, 1'b0, 6'd0});
    wait_write("mid_again", 40);
    chk("mid_again_data", wr_data, 4'hD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
